mudv: RTL

Multiply/divide unit in the E stage of the pipelined MIPS core. It executes `mult`/`multu`/`div`/`divu` over a fixed multi-cycle latency and owns the HI/LO registers. It serves `mthi`/`mtlo`/`mfhi`/`mflo`. Its `occupied` output feeds the D-stage stall controller, which holds any M/D-class instruction in D while the unit is busy.

---
 rtl/mudv_if.sv | 19 +
 rtl/mudv.sv | 119 +++++++++++
 2 files changed

// File: rtl/mudv_if.sv
// mudv_if: E-stage <-> multiply/divide unit connection.
//   master (E stage) drives : en, flush, funct, a, b
//   slave  (mudv)    drives : occupied, rdata, hi, lo
interface mudv_if;
  logic        en;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        occupied;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output en, flush, funct, a, b,
                  input  occupied, rdata, hi, lo);
  modport slave  (input  en, flush, funct, a, b,
                  output occupied, rdata, hi, lo);
endinterface

// File: rtl/mudv.sv
// mudv: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk      : clock
//   reset    : asynchronous active-high reset
//   bus      : mudv_if.slave
//     en/flush/funct/a/b : E-stage M/D instruction and forwarded operands
//     occupied           : unit starting or running an operation (to D-stage stall)
//     rdata              : HI for mfhi, else LO (combinational, committed values)
//     hi/lo              : committed HI/LO
// The result is computed at the start edge and parked in pend_*; it only
// becomes architecturally visible when the latency counter expires.
module mudv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mudv_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic        pend_ok_q;

  // decode
  logic act, start, mthi, mtlo;
  assign act   = bus.en & ~bus.flush;
  assign start = act & (bus.funct[5:3] == 3'o3);
  assign mthi  = act & (bus.funct == 6'o21);
  assign mtlo  = act & (bus.funct == 6'o23);

  // multiply: funct[0] selects unsigned
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // divide: one unsigned divider, signed case runs on magnitudes and
  // fixes signs afterwards (quotient truncates, remainder follows dividend).
  // Divisor 0 is replaced by 1 only to keep the divider defined; that
  // result is never committed.
  logic [31:0] mag_a, mag_b, opa, opb, qq, rr;
  logic        is_u, b_zero;
  assign is_u   = bus.funct[0];
  assign b_zero = (bus.b == 32'd0);
  assign mag_a  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign mag_b  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
  assign opa    = is_u ? bus.a : mag_a;
  assign opb    = b_zero ? 32'd1 : (is_u ? bus.b : mag_b);
  assign qq     = opa / opb;
  assign rr     = opa % opb;

  logic [31:0] res_hi_d, res_lo_d;
  logic        res_ok_d;
  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    res_ok_d = 1'b1;
    if (!bus.funct[1]) begin
      {res_hi_d, res_lo_d} = is_u ? prod_u : prod_s;
    end else begin
      res_ok_d = ~b_zero;
      if (is_u) begin
        res_lo_d = qq;
        res_hi_d = rr;
      end else begin
        res_lo_d = (bus.a[31] ^ bus.b[31]) ? (~qq + 32'd1) : qq;
        res_hi_d = bus.a[31] ? (~rr + 32'd1) : rr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= BUSY;
            cnt_q     <= bus.funct[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_hi_q <= res_hi_d;
            pend_lo_q <= res_lo_d;
            pend_ok_q <= res_ok_d;
          end else begin
            if (mthi) hi_q <= bus.a;
            if (mtlo) lo_q <= bus.a;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            if (pend_ok_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // start is folded in so the D stage stalls in the same cycle
  assign bus.occupied = start | (state_q == BUSY);
  assign bus.rdata    = (bus.funct == 6'o20) ? hi_q : lo_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule
